// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and constants for the up/down counter family.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic {
        IDLE,
        RUN
    } dcnt_state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module      : down_counter
// Description : Loadable N-bit down-counter/timer with one-shot and periodic
//               (auto-reload) modes and a registered one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter
    import counter_pkg::*;
#(
    parameter int N = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

    if (N < 2 || N > 32) begin : g_bad_width
        $error("down_counter: N must be in 2..32");
    end

    dcnt_state_t  r_state;
    dcnt_state_t  w_state_nxt;
    logic [N-1:0] r_q;
    logic [N-1:0] w_q_nxt;
    logic [N-1:0] r_reload;
    logic [N-1:0] w_reload_nxt;
    logic         r_done;
    logic         w_done_nxt;

    logic         w_q_zero;
    logic         w_q_one;
    logic         w_reload_zero;

    assign w_q_zero      = (r_q == '0);
    assign w_q_one       = (r_q == C_ONE);
    assign w_reload_zero = (r_reload == '0);

    // Edge priority: load, then stop, then expiry/decrement, then start.
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;

        if (load) begin
            w_q_nxt      = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = IDLE;
        end else if (stop) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_q_zero) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (w_q_zero) begin
                            // Not reachable in normal use; never underflow.
                            w_state_nxt = IDLE;
                        end else if (w_q_one) begin
                            w_done_nxt = 1'b1;
                            if (periodic && !w_reload_zero) begin
                                w_q_nxt = r_reload;
                            end else begin
                                w_q_nxt     = '0;
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_q_nxt = r_q - C_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign q    = r_q;
    assign busy = (r_state == RUN);
    assign done = r_done;

endmodule : down_counter
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter
// Description : Self-checking bench for down_counter (vector table + queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         periodic = 1'b0;
    logic [N-1:0] q;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    down_counter #(.N(N)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic         ld;
        logic [N-1:0] lv;
        logic         st;
        logic         sp;
        logic         e;
        logic         per;
        logic [N-1:0] eq;
        logic         eb;
        logic         ed;
        string        tag;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic         busy;
        logic         done;
        string        tag;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic ld, input logic [N-1:0] lv,
                                input logic st, input logic sp, input logic e,
                                input logic per, input logic [N-1:0] eq,
                                input logic eb, input logic ed, input string tag);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.e = e; v.per = per;
        v.eq = eq; v.eb = eb; v.ed = ed; v.tag = tag;
        return v;
    endfunction

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            bad++;
            total++;
            $display("FAIL scoreboard empty: nothing expected but output sampled");
            return;
        end
        x = sb.pop_front();
        total++;
        if (q !== x.q) begin
            bad++;
            $display("FAIL %s q: got %0h want %0h", x.tag, q, x.q);
        end
        total++;
        if (busy !== x.busy) begin
            bad++;
            $display("FAIL %s busy: got %0b want %0b", x.tag, busy, x.busy);
        end
        total++;
        if (done !== x.done) begin
            bad++;
            $display("FAIL %s done: got %0b want %0b", x.tag, done, x.done);
        end
    endtask

    task automatic step(input logic r, input vec_t v);
        exp_t x;
        @(negedge clk);
        rst      = r;
        load     = v.ld;
        load_val = v.lv;
        start    = v.st;
        stop     = v.sp;
        en       = v.e;
        periodic = v.per;
        x.q = v.eq; x.busy = v.eb; x.done = v.ed; x.tag = v.tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        // Reset with random stimulus on the other inputs.
        for (int i = 0; i < 2; i++) begin
            v = mk(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 8'h00, 1'b0, 1'b0, "reset");
            step(1'b1, v);
        end

        // One-shot from 5; start held during the run must be ignored.
        vecs.push_back(mk(1, 8'h05, 0, 0, 0, 0, 8'h05, 0, 0, "os_load"));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h05, 1, 0, "os_start"));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h04, 1, 0, "os_4"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h03, 1, 0, "os_3"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h02, 1, 0, "os_2"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h01, 1, 0, "os_1"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, "os_expire"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, "os_after"));

        // Pause: 3 enabled, 4 disabled, 7 enabled cycles to expiry.
        vecs.push_back(mk(1, 8'h0A, 0, 0, 0, 0, 8'h0A, 0, 0, "pz_load"));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h0A, 1, 0, "pz_start"));
        for (int i = 1; i <= 3; i++)
            vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'(10 - i), 1, 0, "pz_run"));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h07, 1, 0, "pz_hold"));
        for (int i = 1; i <= 6; i++)
            vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'(7 - i), 1, 0, "pz_resume"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, "pz_expire"));

        // Periodic reload of 3: 3,2,1,3,2,1,... with done on each reload.
        vecs.push_back(mk(1, 8'h03, 0, 0, 0, 1, 8'h03, 0, 0, "pr_load"));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h03, 1, 0, "pr_start"));
        for (int p = 0; p < 3; p++) begin
            vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h02, 1, 0, "pr_2"));
            vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h01, 1, 0, "pr_1"));
            vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h03, 1, 1, "pr_reload"));
        end
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 8'h03, 0, 0, "pr_stop"));

        // Zero start: immediate done, never busy.
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "z_load"));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, "z_start"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, "z_after"));

        foreach (vecs[i]) step(1'b0, vecs[i]);

        // Load mid-run at q=4 aborts with no done.
        step(1'b0, mk(1, 8'h06, 0, 0, 0, 0, 8'h06, 0, 0, "ab_ld6"));
        step(1'b0, mk(0, 8'h00, 1, 0, 1, 0, 8'h06, 1, 0, "ab_start"));
        step(1'b0, mk(0, 8'h00, 0, 0, 1, 0, 8'h05, 1, 0, "ab_5"));
        step(1'b0, mk(0, 8'h00, 0, 0, 1, 0, 8'h04, 1, 0, "ab_4"));
        step(1'b0, mk(1, 8'h08, 0, 0, 1, 0, 8'h08, 0, 0, "ab_reload8"));
        step(1'b0, mk(0, 8'h00, 0, 0, 1, 0, 8'h08, 0, 0, "ab_idle"));

        // Stop coinciding with expiry at q=1: stop wins.
        step(1'b0, mk(0, 8'h00, 1, 0, 1, 0, 8'h08, 1, 0, "sp_start"));
        for (int i = 1; i <= 7; i++)
            step(1'b0, mk(0, 8'h00, 0, 0, 1, 0, 8'(8 - i), 1, 0, "sp_run"));
        step(1'b0, mk(0, 8'h00, 0, 1, 1, 0, 8'h01, 0, 0, "sp_stop"));
        step(1'b0, mk(0, 8'h00, 0, 0, 1, 0, 8'h01, 0, 0, "sp_after"));

        // Reset mid-run at q=2.
        step(1'b0, mk(1, 8'h04, 0, 0, 0, 0, 8'h04, 0, 0, "rs_load"));
        step(1'b0, mk(0, 8'h00, 1, 0, 1, 0, 8'h04, 1, 0, "rs_start"));
        step(1'b0, mk(0, 8'h00, 0, 0, 1, 0, 8'h03, 1, 0, "rs_3"));
        step(1'b0, mk(0, 8'h00, 0, 0, 1, 0, 8'h02, 1, 0, "rs_2"));
        step(1'b1, mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, "rs_reset"));

        // Reload register is cleared by reset: periodic start from a zero load.
        step(1'b0, mk(0, 8'h00, 1, 0, 1, 1, 8'h00, 0, 1, "rs_zero_start"));

        if (sb.size() != 0) begin
            bad++;
            total++;
            $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_down_counter
`default_nettype wire
